// File: rtl/mul_share_pkg.sv
// Shared widths and payload types for the multiplier-sharing arbiter slice.
package mul_share_pkg;

  localparam int OP_W     = 8;
  localparam int RES_W    = 16;
  localparam int MAX_ID_W = 4;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operand_t;

  // id is sized for the largest supported requester count; narrower builds use the low bits
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [RES_W-1:0]    o;
  } response_t;

endpackage

// File: rtl/multiplier.sv
// Exact 8x8 unsigned multiplier datapath shared by the arbiter.
module multiplier (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] O
);

  assign O = A * B;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant search starting at ptr, via a doubled request vector.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W:0]        sum;
  logic                 found;

  assign dbl     = {req, req};
  assign rot     = NUM_REQ'(dbl >> ptr);
  assign any_req = |req;

  always_comb begin
    found        = 1'b0;
    sum          = '0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (ID_W+1)'(i);
        if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
        grant_idx = sum[ID_W-1:0];
      end
    end
    if (found) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one 8x8 multiplier among NUM_REQ requesters,
// two-stage pipeline (operand register, result register) with a tagged response channel.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][OP_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][OP_W-1:0]  req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [RES_W-1:0]              rsp_o,
  output logic [15:0]                   ops_done
);

  logic                 op_valid;
  operand_t             op_q;
  logic [ID_W-1:0]      op_id;
  logic [ID_W-1:0]      rr_ptr;
  response_t            s2_q;

  logic                 s2_load;
  logic                 s1_free;
  logic                 accept;
  logic                 any_req;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      next_ptr;
  logic [RES_W-1:0]     product;
  logic                 unused_id_bits;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_req      (any_req)
  );

  multiplier u_mul (
    .A (op_q.a),
    .B (op_q.b),
    .O (product)
  );

  assign s2_load   = op_valid && (!rsp_valid || rsp_ready);
  assign s1_free   = !op_valid || s2_load;
  // rst_n gates ready so nothing is handed over on a reset edge
  assign accept    = rst_n && s1_free && any_req;
  assign req_ready = accept ? grant_onehot : '0;
  assign next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  assign rsp_id         = s2_q.id[ID_W-1:0];
  assign rsp_o          = s2_q.o;
  assign unused_id_bits = ^s2_q.id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_valid  <= 1'b0;
      op_q      <= '0;
      op_id     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      s2_q      <= '0;
      ops_done  <= '0;
    end else begin
      if (accept) begin
        op_valid <= 1'b1;
        op_q     <= '{a: req_a[grant_idx], b: req_b[grant_idx]};
        op_id    <= grant_idx;
        rr_ptr   <= next_ptr;
      end else if (s2_load) begin
        op_valid <= 1'b0;
      end

      if (s2_load) begin
        rsp_valid <= 1'b1;
        s2_q      <= '{id: MAX_ID_W'(op_id), o: product};
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (rsp_valid && rsp_ready) ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: randomized requesters, spec-level reference model.
module tb_mul_share_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][7:0]   req_a;
  logic [N-1:0][7:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [15:0]         rsp_o;
  logic [15:0]         ops_done;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .NUM_REQ (N),
    .ID_W    (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_o     (rsp_o),
    .ops_done  (ops_done)
  );

  typedef struct {
    int unsigned id;
    int unsigned prod;
  } exp_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  exp_t        sb[$];

  int unsigned model_ptr  = 0;
  int unsigned model_ops  = 0;
  int unsigned acc_count  = 0;
  logic [N-1:0] acc_seen  = '0;
  bit          fair_mode  = 1'b0;
  int unsigned fair_next  = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_o;
  logic [IW-1:0] prev_id;

  bit          drive_rand = 1'b0;
  int unsigned p_valid    = 0;
  int unsigned p_ready    = 0;
  logic [N-1:0] en_mask   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(7))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // Reference model and monitor: look at the cycle just before the coming rising edge.
  int unsigned  inflight;
  int unsigned  g;
  int unsigned  idx;
  bit           found;
  bit           exp_any;
  logic [N-1:0] acc;
  logic [N-1:0] oh;
  exp_t         e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("ready_in_reset", 32'(req_ready), 32'd0);
      sb.delete();
      model_ptr  = 0;
      model_ops  = 0;
      prev_stall = 1'b0;
      acc_seen   = '0;
    end else begin
      inflight = sb.size();
      exp_any  = (|req_valid) && (inflight < 2 || rsp_ready);
      chk("ready_any", 32'(|req_ready), 32'(exp_any));

      found = 1'b0;
      g     = 0;
      for (int unsigned k = 0; k < N; k++) begin
        idx = (model_ptr + k) % N;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      if (exp_any) begin
        oh    = '0;
        oh[g] = 1'b1;
        chk("grant", 32'(req_ready), 32'(oh));
      end

      if (rsp_valid) chk("no_stale_rsp", 32'(inflight != 0), 32'd1);

      if (prev_stall) begin
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_o", 32'(rsp_o), 32'(prev_o));
        chk("stall_id", 32'(rsp_id), 32'(prev_id));
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_o     = rsp_o;
      prev_id    = rsp_id;

      chk("ops_done", 32'(ops_done), model_ops & 32'hFFFF);
      if (model_ops == 65537) chk("ops_wrap", 32'(ops_done), 32'h0001);

      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_pop: response id=%0d o=0x%0h with nothing outstanding", rsp_id, rsp_o);
        end else begin
          e = sb.pop_front();
          checks++;
          if (32'(rsp_id) !== e.id || 32'(rsp_o) !== e.prod) begin
            failures++;
            $display("FAIL rsp_data: got id=%0d o=0x%0h required id=%0d o=0x%0h",
                     rsp_id, rsp_o, e.id, e.prod);
          end
        end
        model_ops++;
      end

      acc = req_valid & req_ready;
      if (fair_mode) chk("fair_one_accept", 32'($countones(acc)), 32'd1);
      for (int unsigned i = 0; i < N; i++) begin
        if (acc[i]) begin
          sb.push_back('{id: i, prod: int'(req_a[i]) * int'(req_b[i])});
          model_ptr = (i + 1) % N;
          acc_count++;
          if (fair_mode) begin
            chk("fair_order", i, fair_next);
            fair_next = (fair_next + 1) % N;
          end
        end
      end
      acc_seen = acc;
    end
  end

  // Inputs change 1 time unit after the rising edge; valid/data held until accepted.
  task automatic drive_cycle();
    @(posedge clk);
    #1;
    if (drive_rand) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!req_valid[i] || acc_seen[i]) begin
          req_valid[i] = en_mask[i] && ($urandom_range(99) < p_valid);
          req_a[i]     = pick();
          req_b[i]     = pick();
        end
      end
      rsp_ready = ($urandom_range(99) < p_ready);
    end
  endtask

  task automatic do_reset();
    drive_cycle();
    rst_n = 1'b0;
    drive_cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    drive_rand = 1'b0;
    req_valid  = '0;
    rsp_ready  = 1'b1;
    for (int unsigned c = 0; c < 20 && sb.size() != 0; c++) drive_cycle();
    drive_cycle();
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  // Idle pipeline assumed: accept on the next edge, product visible one edge later.
  task automatic send_check(input string name, input int unsigned id,
                            input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    drive_cycle();
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_a[id]     = a;
    req_b[id]     = b;
    rsp_ready     = 1'b1;
    @(negedge clk);
    oh     = '0;
    oh[id] = 1'b1;
    chk({name, "_ready"}, 32'(req_ready), 32'(oh));
    drive_cycle();
    req_valid = '0;
    @(negedge clk);
    chk({name, "_lat"}, 32'(rsp_valid), 32'd0);
    drive_cycle();
    @(negedge clk);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_o"}, 32'(rsp_o), 32'(exp));
    chk({name, "_id"}, 32'(rsp_id), id);
  endtask

  int unsigned a0;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) drive_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_o", 32'(rsp_o), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    send_check("single", 2, 8'h0C, 8'h0D, 16'h009C);
    drive_cycle();
    @(negedge clk);
    chk("single_ops_done", 32'(ops_done), 32'd1);
    chk("single_done", 32'(rsp_valid), 32'd0);

    send_check("ff_ff", 0, 8'hFF, 8'hFF, 16'hFE01);
    send_check("zero", 1, 8'h00, 8'hA5, 16'h0000);
    send_check("x80", 3, 8'h80, 8'h02, 16'h0100);
    drain();

    // Fairness: everyone valid from reset, response never stalled
    do_reset();
    drive_rand = 1'b1;
    p_valid    = 100;
    p_ready    = 100;
    en_mask    = '1;
    drive_cycle();
    fair_mode = 1'b1;
    fair_next = 0;
    repeat (20) drive_cycle();
    fair_mode = 1'b0;
    drain();

    // Back-pressure: requester 1 streams while the response side is stalled
    drive_rand = 1'b1;
    en_mask    = 4'b0010;
    p_valid    = 100;
    p_ready    = 0;
    drive_cycle();
    a0 = acc_count;
    repeat (4) drive_cycle();
    @(negedge clk);
    chk("bp_accepts", acc_count - a0, 32'd2);
    chk("bp_ready_zero", 32'(req_ready), 32'd0);
    p_ready = 100;
    repeat (10) drive_cycle();
    drain();

    // Reset with both stages occupied
    drive_rand = 1'b1;
    en_mask    = '1;
    p_valid    = 100;
    p_ready    = 0;
    repeat (4) drive_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    drive_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_ops_done", 32'(ops_done), 32'd0);
    p_ready = 50;
    repeat (20) drive_cycle();

    // Randomized mixed traffic
    p_valid = 60;
    p_ready = 70;
    repeat (3000) drive_cycle();
    drain();

    // Counter wrap: full-rate traffic past 65536 handshakes
    do_reset();
    drive_rand = 1'b1;
    en_mask    = '1;
    p_valid    = 100;
    p_ready    = 100;
    for (int unsigned c = 0; c < 70000 && model_ops < 65540; c++) drive_cycle();
    chk("wrap_reached", 32'(model_ops >= 65540), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
